// File: rtl/car_sensor_driver_pkg.sv
// Shared types and sensor encodings for the A/B gate waveform driver.
package car_sensor_driver_pkg;

    typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP} drv_state_t;
    typedef enum logic {DIR_ENTER, DIR_EXIT} dir_t;

    localparam logic [1:0] AB_CLEAR = 2'b00;
    localparam logic [1:0] AB_OUTER = 2'b10;
    localparam logic [1:0] AB_BOTH  = 2'b11;
    localparam logic [1:0] AB_INNER = 2'b01;

    // Exit is the enter waveform with the outer and inner sensors swapped.
    function automatic logic [1:0] ab_pattern(input drv_state_t s, input dir_t d);
        logic [1:0] ab;
        ab = AB_CLEAR;
        case (s)
            PH1:     ab = (d == DIR_ENTER) ? AB_OUTER : AB_INNER;
            PH2:     ab = AB_BOTH;
            PH3:     ab = (d == DIR_ENTER) ? AB_INNER : AB_OUTER;
            default: ab = AB_CLEAR;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/car_sensor_driver_if.sv
// Request/status bundle between a requester (master) and the sensor driver (slave).
interface car_sensor_driver_if #(
    parameter int unsigned CAPACITY = 25
);
    localparam int unsigned CNT_W = $clog2(CAPACITY + 1);

    logic             req_enter;
    logic             req_exit;
    logic             ready;
    logic             done;
    logic             rejected;
    logic             A;
    logic             B;
    logic [CNT_W-1:0] occupancy;

    modport master (
        output req_enter, req_exit,
        input  ready, done, rejected, A, B, occupancy
    );

    modport slave (
        input  req_enter, req_exit,
        output ready, done, rejected, A, B, occupancy
    );

endinterface

// File: rtl/car_sensor_driver_dwell_timer.sv
// Phase timer: expire is high during the last cycle of a DWELL-cycle phase.
module dwell_timer #(
    parameter int unsigned DWELL = 2
) (
    input  logic clk,
    input  logic i_clr_n,
    input  logic i_load,
    output logic o_expire
);
    localparam int unsigned TW = $clog2(DWELL + 1);

    logic [TW-1:0] r_cnt;
    logic          r_run;

    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_load) begin
            r_cnt <= TW'(DWELL - 1);
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == '0)
                r_run <= 1'b0;
            else
                r_cnt <= r_cnt - TW'(1);
        end
    end

    assign o_expire = r_run && (r_cnt == '0);

endmodule

// File: rtl/car_sensor_driver.sv
// Emits enter/exit A/B sensor sequences and tracks the resulting lot occupancy.
module car_sensor_driver
    import car_sensor_driver_pkg::*;
#(
    parameter int unsigned DWELL    = 2,
    parameter int unsigned CAPACITY = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    car_sensor_driver_if.slave   bus
);
    localparam int unsigned    CNT_W   = $clog2(CAPACITY + 1);
    localparam logic [CNT_W-1:0] CAP_VAL = CNT_W'(CAPACITY);

    drv_state_t       r_state, w_state_nxt;
    dir_t             r_dir, w_dir_nxt;
    logic [CNT_W-1:0] r_occ, w_occ_nxt;
    logic [1:0]       r_ab, w_ab_nxt;
    logic             r_ready, r_done, r_rejected;
    logic             w_ready_nxt, w_done_nxt, w_rej_nxt;
    logic             w_accept, w_reject, w_expire, w_load;

    dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk      (clk),
        .i_clr_n  (reset),
        .i_load   (w_load),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_dir      <= DIR_ENTER;
            r_occ      <= '0;
            r_ab       <= AB_CLEAR;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_rejected <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dir      <= w_dir_nxt;
            r_occ      <= w_occ_nxt;
            r_ab       <= w_ab_nxt;
            r_ready    <= w_ready_nxt;
            r_done     <= w_done_nxt;
            r_rejected <= w_rej_nxt;
        end
    end

    // Enter wins when both requests arrive together; exit is then dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_enter) begin
                    if (r_occ == CAP_VAL) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept  = 1'b1;
                        w_dir_nxt = DIR_ENTER;
                    end
                end else if (bus.req_exit) begin
                    if (r_occ == '0) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept  = 1'b1;
                        w_dir_nxt = DIR_EXIT;
                    end
                end
                if (w_accept)
                    w_state_nxt = PH1;
            end
            PH1:     if (w_expire) w_state_nxt = PH2;
            PH2:     if (w_expire) w_state_nxt = PH3;
            PH3:     if (w_expire) w_state_nxt = GAP;
            GAP:     if (w_expire) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_load = w_accept || (w_expire && (r_state inside {PH1, PH2, PH3}));
    end

    // Outputs are computed for the next state so every port comes straight from a flop.
    always_comb begin
        w_ab_nxt    = ab_pattern(w_state_nxt, w_dir_nxt);
        w_ready_nxt = (w_state_nxt == IDLE);
        w_done_nxt  = (r_state == GAP) && w_expire;
        w_rej_nxt   = w_reject;
        w_occ_nxt   = r_occ;
        if (w_done_nxt) begin
            if (r_dir == DIR_ENTER && r_occ != CAP_VAL)
                w_occ_nxt = r_occ + CNT_W'(1);
            else if (r_dir == DIR_EXIT && r_occ != '0)
                w_occ_nxt = r_occ - CNT_W'(1);
        end
    end

    assign bus.A         = r_ab[1];
    assign bus.B         = r_ab[0];
    assign bus.ready     = r_ready;
    assign bus.done      = r_done;
    assign bus.rejected  = r_rejected;
    assign bus.occupancy = r_occ;

endmodule

// File: tb/tb_car_sensor_driver.sv
// Self-checking bench for car_sensor_driver against a sequence-level reference model.
module tb_car_sensor_driver;

    localparam int unsigned DWELL    = 2;
    localparam int unsigned CAPACITY = 3;
    localparam int unsigned SEQ_LEN  = 4 * DWELL;
    localparam int unsigned NO_POKE  = SEQ_LEN;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    car_sensor_driver_if #(.CAPACITY(CAPACITY)) bus ();

    car_sensor_driver #(.DWELL(DWELL), .CAPACITY(CAPACITY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int m_occ = 0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Waveform seen t cycles into a sequence: one pattern per DWELL-long phase.
    function automatic logic [1:0] exp_ab(input bit enter, input int unsigned t);
        logic [1:0] ent [4];
        logic [1:0] ext [4];
        ent = '{2'b10, 2'b11, 2'b01, 2'b00};
        ext = '{2'b01, 2'b11, 2'b10, 2'b00};
        return enter ? ent[t / DWELL] : ext[t / DWELL];
    endfunction

    task automatic run_req(input bit en, input bit ex, input int unsigned poke_at, input string tag);
        int unsigned guard;
        bit          refuse;
        logic [4:0]  exp_v;
        guard = 0;
        while (bus.ready !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        total++;
        if (guard == 100) begin
            $display("FAIL %s_ready_wait: ready=%b required 1", tag, bus.ready);
            bad++;
        end
        if (!en && !ex) return;
        refuse = en ? (m_occ == CAPACITY) : (m_occ == 0);
        bus.req_enter = en;
        bus.req_exit  = ex;
        step();
        bus.req_enter = 1'b0;
        bus.req_exit  = 1'b0;
        if (refuse) begin
            total++;
            if ({bus.A, bus.B, bus.ready, bus.done, bus.rejected} !== 5'b00101 || bus.occupancy !== m_occ) begin
                $display("FAIL %s_reject: AB/rdy/done/rej=%b occ=%0d required 00101 occ=%0d",
                         tag, {bus.A, bus.B, bus.ready, bus.done, bus.rejected}, bus.occupancy, m_occ);
                bad++;
            end
            step();
            total++;
            if (bus.rejected !== 1'b0) begin
                $display("FAIL %s_reject_pulse: rejected=%b required 0", tag, bus.rejected);
                bad++;
            end
            return;
        end
        for (int unsigned t = 0; t < SEQ_LEN; t++) begin
            if (t != 0) step();
            bus.req_enter = 1'b0;
            bus.req_exit  = 1'b0;
            exp_v = {exp_ab(en, t), 3'b000};
            total++;
            if ({bus.A, bus.B, bus.ready, bus.done, bus.rejected} !== exp_v) begin
                $display("FAIL %s_seq t=%0d: AB/rdy/done/rej=%b required %b",
                         tag, t, {bus.A, bus.B, bus.ready, bus.done, bus.rejected}, exp_v);
                bad++;
            end
            if (t == poke_at) begin
                bus.req_enter = 1'b1;
                bus.req_exit  = 1'b1;
            end
        end
        step();
        bus.req_enter = 1'b0;
        bus.req_exit  = 1'b0;
        m_occ = en ? m_occ + 1 : m_occ - 1;
        total++;
        if ({bus.A, bus.B, bus.ready, bus.done, bus.rejected} !== 5'b00110 || bus.occupancy !== m_occ) begin
            $display("FAIL %s_done: AB/rdy/done/rej=%b occ=%0d required 00110 occ=%0d",
                     tag, {bus.A, bus.B, bus.ready, bus.done, bus.rejected}, bus.occupancy, m_occ);
            bad++;
        end
        step();
        total++;
        if ({bus.A, bus.B, bus.ready, bus.done} !== 4'b0010) begin
            $display("FAIL %s_after_done: AB/rdy/done=%b required 0010",
                     tag, {bus.A, bus.B, bus.ready, bus.done});
            bad++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.req_enter = 1'b0;
        bus.req_exit  = 1'b0;
        step();
        step();
        m_occ = 0;
        total++;
        if ({bus.A, bus.B, bus.ready, bus.done, bus.rejected} !== 5'b00100 || bus.occupancy !== 0) begin
            $display("FAIL reset: AB/rdy/done/rej=%b occ=%0d required 00100 occ=0",
                     {bus.A, bus.B, bus.ready, bus.done, bus.rejected}, bus.occupancy);
            bad++;
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_enter;
        run_req(1'b1, 1'b0, NO_POKE, "enter");
    endtask

    task automatic test_exit;
        run_req(1'b0, 1'b1, NO_POKE, "exit");
    endtask

    task automatic test_empty_full;
        run_req(1'b0, 1'b1, NO_POKE, "exit_empty");
        for (int i = 0; i < 3; i++) run_req(1'b1, 1'b0, NO_POKE, "fill");
        run_req(1'b1, 1'b0, NO_POKE, "enter_full");
    endtask

    task automatic test_simultaneous;
        test_reset();
        run_req(1'b1, 1'b0, NO_POKE, "pre_simul");
        run_req(1'b1, 1'b1, NO_POKE, "simul");
        run_req(1'b1, 1'b0, DWELL, "poke_ph2");
    endtask

    task automatic test_reset_mid;
        run_req(1'b0, 1'b1, NO_POKE, "pre_mid");
        bus.req_enter = 1'b1;
        step();
        bus.req_enter = 1'b0;
        step();
        step();
        total++;
        if ({bus.A, bus.B} !== 2'b11) begin
            $display("FAIL mid_in_ph2: AB=%b required 11", {bus.A, bus.B});
            bad++;
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        m_occ = 0;
        total++;
        if ({bus.A, bus.B, bus.ready, bus.done} !== 4'b0010 || bus.occupancy !== 0) begin
            $display("FAIL mid_reset: AB/rdy/done=%b occ=%0d required 0010 occ=0",
                     {bus.A, bus.B, bus.ready, bus.done}, bus.occupancy);
            bad++;
        end
        for (int i = 0; i < SEQ_LEN + 2; i++) begin
            step();
            total++;
            if (bus.done !== 1'b0 || {bus.A, bus.B} !== 2'b00) begin
                $display("FAIL mid_quiet i=%0d: done=%b AB=%b required 0 00", i, bus.done, {bus.A, bus.B});
                bad++;
            end
        end
        run_req(1'b1, 1'b0, NO_POKE, "after_mid");
    endtask

    task automatic test_back_to_back;
        bus.req_enter = 1'b1;
        step();
        for (int rep = 0; rep < 2; rep++) begin
            for (int unsigned t = 0; t < SEQ_LEN; t++) begin
                if (t != 0 || rep != 0) step();
                total++;
                if ({bus.A, bus.B, bus.ready, bus.done} !== {exp_ab(1'b1, t), 2'b00}) begin
                    $display("FAIL b2b rep=%0d t=%0d: AB/rdy/done=%b required %b", rep, t,
                             {bus.A, bus.B, bus.ready, bus.done}, {exp_ab(1'b1, t), 2'b00});
                    bad++;
                end
            end
            step();
            m_occ++;
            if (rep == 1) bus.req_enter = 1'b0;
            total++;
            if ({bus.A, bus.B, bus.ready, bus.done} !== 4'b0011 || bus.occupancy !== m_occ) begin
                $display("FAIL b2b_done rep=%0d: AB/rdy/done=%b occ=%0d required 0011 occ=%0d", rep,
                         {bus.A, bus.B, bus.ready, bus.done}, bus.occupancy, m_occ);
                bad++;
            end
        end
        step();
        total++;
        if ({bus.A, bus.B, bus.ready, bus.done} !== 4'b0010) begin
            $display("FAIL b2b_end: AB/rdy/done=%b required 0010", {bus.A, bus.B, bus.ready, bus.done});
            bad++;
        end
    endtask

    task automatic test_random;
        bit          en, ex;
        int unsigned poke, gap;
        test_reset();
        for (int i = 0; i < 40; i++) begin
            en   = 1'($urandom % 2);
            ex   = 1'($urandom % 2);
            poke = $urandom_range(0, SEQ_LEN);
            gap  = $urandom_range(0, 2);
            for (int unsigned g = 0; g < gap; g++) step();
            run_req(en, ex, poke, "random");
        end
    endtask

    initial begin
        bus.req_enter = 1'b0;
        bus.req_exit  = 1'b0;
        reset = 1'b0;
        test_reset();
        test_enter();
        test_exit();
        test_empty_full();
        test_simultaneous();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
